// File: rtl/bch_syndrome_serial.sv
// rtl/bch_syndrome_serial.sv - bit-serial odd BCH syndromes S1..S(2T-1), MSB-first Horner evaluation
module bch_syndrome_serial #(
  parameter int M = 4,
  parameter int T = 2,
  parameter int N = (1 << M) - 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           data_in,
  input  logic           data_valid,
  output logic           data_ready,
  output logic [M*T-1:0] syn,
  output logic           syn_valid,
  input  logic           syn_ready,
  output logic           syn_zero
);

  localparam int CW = $clog2(N + 1);

  function automatic int poly_for(input int deg);
    case (deg)
      3:       return 'h0B;
      4:       return 'h13;
      5:       return 'h25;
      6:       return 'h43;
      7:       return 'h89;
      8:       return 'h11D;
      9:       return 'h211;
      10:      return 'h409;
      11:      return 'h805;
      12:      return 'h1053;
      13:      return 'h201B;
      14:      return 'h4443;
      15:      return 'h8003;
      16:      return 'h1100B;
      default: return 0;
    endcase
  endfunction

  localparam int            POLY_INT = poly_for(M);
  localparam logic [M-1:0]  POLY_LO  = POLY_INT[M-1:0];

  // Multiply by alpha: shift left, fold the x^M term back through the field polynomial.
  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY_LO : '0);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [M*T-1:0]   acc_q, acc_d;
  logic [M*T-1:0]   upd;
  logic [M*T-1:0]   syn_q, syn_d;
  logic             syn_valid_q, syn_valid_d;
  logic             syn_zero_q, syn_zero_d;
  logic             data_ready_q, data_ready_d;

  // Accumulator j is scaled by alpha^j via 2i+1 chained alpha multiplies.
  always_comb begin
    logic [M-1:0] tmp;
    tmp = '0;
    upd = '0;
    for (int i = 0; i < T; i++) begin
      tmp = acc_q[M*i +: M];
      for (int k = 0; k < 2*T; k++) begin
        if (k <= 2*i) tmp = mul_alpha(tmp);
      end
      upd[M*i +: M] = tmp ^ {{(M-1){1'b0}}, data_in};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    syn_d       = syn_q;
    syn_valid_d = syn_valid_q;
    syn_zero_d  = syn_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
        end else if (data_valid) begin
          acc_d = upd;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            syn_d       = upd;
            syn_zero_d  = (upd == '0);
            syn_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (syn_ready) begin
          syn_valid_d = 1'b0;
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    data_ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      syn_q        <= '0;
      syn_valid_q  <= 1'b0;
      syn_zero_q   <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      syn_q        <= syn_d;
      syn_valid_q  <= syn_valid_d;
      syn_zero_q   <= syn_zero_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign syn        = syn_q;
  assign syn_valid  = syn_valid_q;
  assign syn_zero   = syn_zero_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_bch_syndrome_serial.sv
// tb/tb_bch_syndrome_serial.sv - self-checking bench for bch_syndrome_serial (M=4, T=2, N=15)
module tb_bch_syndrome_serial;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       data_in = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [7:0] syn;
  logic       syn_valid;
  logic       syn_ready = 1'b0;
  logic       syn_zero;

  bch_syndrome_serial #(.M(4), .T(2), .N(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .syn        (syn),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_zero   (syn_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] bits;
    bit          gaps;
    int          stall;
    logic [7:0]  exp_syn;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_pushed = 0;
  int   n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent model: S_j = sum over set degrees d of alpha^(j*d mod 15).
  function automatic logic [7:0] model(input logic [14:0] bits);
    logic [3:0] pw [15];
    logic [4:0] p;
    logic [3:0] s1, s3;
    p = 5'd1;
    for (int k = 0; k < 15; k++) begin
      pw[k] = p[3:0];
      p = p << 1;
      if (p[4]) p = p ^ 5'h13;
    end
    s1 = '0;
    s3 = '0;
    for (int d = 0; d < 15; d++) begin
      if (bits[d]) begin
        s1 = s1 ^ pw[d % 15];
        s3 = s3 ^ pw[(3 * d) % 15];
      end
    end
    return {s3, s1};
  endfunction

  task automatic push(input logic [7:0] s, input logic z);
    exp_t e;
    e.s = s;
    e.z = z;
    q.push_back(e);
    n_pushed++;
  endtask

  always @(negedge clk) begin
    if (syn_valid && syn_ready) begin
      n_results++;
      if (q.size() == 0) begin
        check("unexpected_result", 32'(syn_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("syn", 32'(syn), 32'(e.s));
        check("syn_zero", 32'(syn_zero), 32'(e.z));
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [14:0] bits, input bit gaps);
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        data_valid = 1'b0;
        @(posedge clk); #1;
      end
      data_valid = 1'b1;
      data_in = bits[i];
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    data_in = 1'b0;
    check("latency_syn_valid", 32'(syn_valid), 32'd1);
  endtask

  task automatic drain(input int stall);
    for (int k = 0; k < stall; k++) begin
      check("stall_syn_valid", 32'(syn_valid), 32'd1);
      check("stall_data_ready", 32'(data_ready), 32'd0);
      start = (k % 2 == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    syn_ready = 1'b1;
    @(posedge clk); #1;
    syn_ready = 1'b0;
    check("released_syn_valid", 32'(syn_valid), 32'd0);
    check("idle_data_ready", 32'(data_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic [14:0] r;
    vecs[0] = '{bits: 15'h0000, gaps: 0, stall: 0, exp_syn: 8'h00, exp_zero: 1'b1};
    vecs[1] = '{bits: 15'h0001, gaps: 0, stall: 0, exp_syn: 8'h11, exp_zero: 1'b0};
    vecs[2] = '{bits: 15'h4000, gaps: 0, stall: 0, exp_syn: 8'hF9, exp_zero: 1'b0};
    vecs[3] = '{bits: 15'h0002, gaps: 0, stall: 0, exp_syn: 8'h82, exp_zero: 1'b0};
    vecs[4] = '{bits: 15'h4000, gaps: 1, stall: 5, exp_syn: 8'hF9, exp_zero: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_data_ready", 32'(data_ready), 32'd0);
    check("reset_syn_valid", 32'(syn_valid), 32'd0);
    check("reset_syn", 32'(syn), 32'd0);
    check("reset_syn_zero", 32'(syn_zero), 32'd0);

    for (int v = 0; v < 5; v++) begin
      push(vecs[v].exp_syn, vecs[v].exp_zero);
      do_start();
      check("run_data_ready", 32'(data_ready), 32'd1);
      send_bits(vecs[v].bits, vecs[v].gaps);
      drain(vecs[v].stall);
    end

    // Reset in the middle of a frame, then a clean all-zero frame.
    do_start();
    for (int i = 0; i < 7; i++) begin
      data_valid = 1'b1;
      data_in = 1'b1;
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_data_ready", 32'(data_ready), 32'd0);
    check("midreset_syn_valid", 32'(syn_valid), 32'd0);
    check("midreset_syn", 32'(syn), 32'd0);
    check("midreset_syn_zero", 32'(syn_zero), 32'd0);
    push(8'h00, 1'b1);
    do_start();
    send_bits(15'h0000, 0);
    drain(0);

    // Abort with start colliding with a valid 1 bit.
    push(8'h11, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1;
      data_in = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b1;
    data_valid = 1'b1;
    data_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_valid = 1'b0;
    check("abort_data_ready", 32'(data_ready), 32'd1);
    check("abort_syn_valid", 32'(syn_valid), 32'd0);
    send_bits(15'h0001, 0);
    drain(0);

    // Back-to-back frames: start on the handshake cycle.
    push(8'hF9, 1'b0);
    do_start();
    send_bits(15'h4000, 0);
    push(8'h82, 1'b0);
    syn_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    syn_ready = 1'b0;
    start = 1'b0;
    check("b2b_data_ready", 32'(data_ready), 32'd1);
    check("b2b_syn_valid", 32'(syn_valid), 32'd0);
    send_bits(15'h0002, 0);
    drain(0);

    // Random frames checked against the power-sum model.
    for (int n = 0; n < 4; n++) begin
      r = 15'($urandom);
      push(model(r), (model(r) == 8'h00));
      do_start();
      send_bits(r, (n % 2 == 1));
      drain(n);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
